// File: rtl/rx_mac_unloader_if.sv
// rx_mac_unloader_if: payload byte stream with valid/ready handshake and last marker
interface rx_mac_unloader_if;
  logic [7:0] data;
  logic valid;
  logic ready;
  logic last;
  modport master (output data, valid, last, input ready);
  modport slave (input data, valid, last, output ready);
endinterface

// File: rtl/rx_mac_unloader.sv
// rx_mac_unloader: claims a filled Rx MAC bank, parses its header and streams the payload out
module rx_mac_unloader #(
  parameter int aw = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic [1:0] rx_mac_buf_status,
  output logic rx_mac_hbank,
  output logic [aw:0] rd_a,
  input  logic [7:0] rd_d,
  rx_mac_unloader_if.master m,
  output logic [10:0] pkt_len,
  output logic [7:0] pkt_status,
  output logic pkt_stb,
  output logic len_err
);
  typedef enum logic [2:0] {idle, claim, hdr, stream, drain} state_t;
  localparam logic [31:0] cap = (32'd1 << aw) - 32'd4;
  state_t st_q, st_d;
  logic hbank_q, hbank_d, bank_q, bank_d;
  logic [aw:0] rd_a_q, rd_a_d;
  logic [6:0] lo_q, lo_d;
  logic [3:0] hi_q, hi_d;
  logic [10:0] len_q, len_d, rem_q, rem_d, len_raw;
  logic [7:0] status_q, status_d;
  logic stb_q, stb_d, err_q, err_d, vld_q, vld_d, vlast_q, vlast_d;
  logic [8:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d, c1;
  logic pop, rd_en, hdr_end, big;
  always_comb begin
    pop = cnt_q != 2'd0 && m.ready;
    c1 = cnt_q - {1'b0, pop};
    cnt_d = c1 + {1'b0, vld_q};
    e0_d = (vld_q && c1 == 2'd0) ? {vlast_q, rd_d} : pop ? e1_q : e0_q;
    e1_d = (vld_q && c1 == 2'd1) ? {vlast_q, rd_d} : e1_q;
    rd_en = st_q == stream && cnt_d != 2'd2;
    vld_d = rd_en;
    vlast_d = rd_en && rem_q == 11'd1;
    hdr_end = st_q == hdr && rd_a_q[1:0] == 2'd3;
    len_raw = {hi_q, lo_q};
    big = {21'd0, len_raw} > cap;
    lo_d = (st_q == hdr && rd_a_q[1:0] == 2'd1) ? rd_d[6:0] : lo_q;
    hi_d = (st_q == hdr && rd_a_q[1:0] == 2'd2) ? rd_d[3:0] : hi_q;
    len_d = hdr_end ? (big ? cap[10:0] : len_raw) : len_q;
    status_d = hdr_end ? rd_d : status_q;
    stb_d = hdr_end;
    err_d = err_q | (hdr_end && big);
    rem_d = hdr_end ? len_d : rem_q - 11'(rd_en);
    rd_a_d = st_q == claim ? {bank_q, {aw{1'b0}}} : {rd_a_q[aw], rd_a_q[aw-1:0] + aw'(st_q == hdr || rd_en)};
    st_d = st_q;
    hbank_d = hbank_q;
    bank_d = bank_q;
    case (st_q)
      idle: if (rx_mac_buf_status[1] == rx_mac_buf_status[0] && rx_mac_buf_status[1] == hbank_q) begin
        st_d = claim;
        hbank_d = ~hbank_q;
        bank_d = ~hbank_q;
      end
      claim: st_d = rx_mac_buf_status[1] == hbank_q ? hdr : claim;
      hdr: st_d = hdr_end ? (len_d == 11'd0 ? idle : stream) : hdr;
      stream: st_d = vlast_d ? drain : stream;
      drain: st_d = (pop && e0_q[8]) ? idle : drain;
      default: st_d = idle;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= idle;
      hbank_q <= 1'b1;
      bank_q <= 1'b0;
      rd_a_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      len_q <= '0;
      rem_q <= '0;
      status_q <= '0;
      stb_q <= 1'b0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
      vlast_q <= 1'b0;
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      hbank_q <= hbank_d;
      bank_q <= bank_d;
      rd_a_q <= rd_a_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      len_q <= len_d;
      rem_q <= rem_d;
      status_q <= status_d;
      stb_q <= stb_d;
      err_q <= err_d;
      vld_q <= vld_d;
      vlast_q <= vlast_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
    end
  end
  assign rx_mac_hbank = hbank_q;
  assign rd_a = rd_a_q;
  assign m.data = e0_q[7:0];
  assign m.valid = cnt_q != 2'd0;
  assign m.last = e0_q[8] && cnt_q != 2'd0;
  assign pkt_len = len_q;
  assign pkt_status = status_q;
  assign pkt_stb = stb_q;
  assign len_err = err_q;
endmodule

// File: tb/tb_rx_mac_unloader.sv
// tb_rx_mac_unloader: randomized bench against a packet-level writer and stream model
module tb_rx_mac_unloader;
  localparam int aw = 11;
  localparam int cap = (1 << aw) - 4;
  typedef struct packed {logic [10:0] len; logic [7:0] st; logic bank; logic err;} hdr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] status;
  logic hbank;
  logic [aw:0] rd_a;
  logic [7:0] rd_d;
  logic [10:0] pkt_len;
  logic [7:0] pkt_status;
  logic pkt_stb, len_err;
  logic s1, s2;
  logic mac_bank = 1'b0;
  logic [7:0] mem [0:(2 << aw) - 1];
  logic [8:0] exp_q[$];
  hdr_t hdr_q[$];
  logic model_err = 1'b0;
  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;
  int beats = 0;
  int top_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  rx_mac_unloader_if s();
  rx_mac_unloader #(.aw(aw)) dut (
    .clk(clk), .rst(rst), .rx_mac_buf_status(status), .rx_mac_hbank(hbank),
    .rd_a(rd_a), .rd_d(rd_d), .m(s), .pkt_len(pkt_len), .pkt_status(pkt_status),
    .pkt_stb(pkt_stb), .len_err(len_err)
  );
  always #5 clk = ~clk;
  assign status = {s2, mac_bank};
  always @(posedge clk) begin
    rd_d <= mem[rd_a];
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= hbank;
      s2 <= s1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic publish(input logic [10:0] len, input logic [7:0] st, input int base);
    int n = 0;
    int l;
    logic b;
    logic [7:0] v;
    hdr_t h;
    while (mac_bank == s2 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("writer_free", 32'(mac_bank != s2), 1);
    b = ~s2;
    l = int'(len) > cap ? cap : int'(len);
    mem[{b, aw'(0)}] = {1'b1, len[6:0]};
    mem[{b, aw'(1)}] = {4'h0, len[10:7]};
    mem[{b, aw'(2)}] = st;
    mem[{b, aw'(3)}] = 8'h00;
    for (int i = 0; i < l; i++) begin
      v = base < 0 ? 8'($urandom) : 8'(base + i);
      mem[{b, aw'(i + 4)}] = v;
      exp_q.push_back({i == l - 1, v});
    end
    model_err = model_err | (int'(len) > cap);
    h.len = 11'(l);
    h.st = st;
    h.bank = b;
    h.err = model_err;
    hdr_q.push_back(h);
    mac_bank = s2;
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || hdr_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", 32'(exp_q.size() + hdr_q.size()), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask
  initial begin
    int b0, n, t;
    logic pv, pr, pstb;
    logic [8:0] pe, e;
    hdr_t h;
    for (int i = 0; i < (2 << aw); i++) mem[i] = 8'h00;
    s.ready = 1'b1;
    pv = 1'b0;
    pr = 1'b0;
    pstb = 1'b0;
    pe = '0;
    fork
      forever begin
        @(posedge clk); #1;
        s.ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~s.ready : ($urandom_range(0, 3) != 0);
      end
      forever begin
        @(negedge clk);
        if (rst) begin
          pv = 1'b0;
          pstb = 1'b0;
        end else begin
          if (pv && !pr) begin
            chk("hold_valid", 32'(s.valid), 1);
            chk("hold_beat", 32'({s.last, s.data}), 32'(pe));
          end
          if (pstb) chk("stb_pulse", 32'(pkt_stb), 0);
          if (pkt_stb) begin
            chk("stb_expected", 32'(hdr_q.size() != 0), 1);
            if (hdr_q.size() != 0) begin
              h = hdr_q.pop_front();
              chk("pkt_len", 32'(pkt_len), 32'(h.len));
              chk("pkt_status", 32'(pkt_status), 32'(h.st));
              chk("len_err", 32'(len_err), 32'(h.err));
              chk("rd_bank", 32'(rd_a[aw]), 32'(h.bank));
              chk("hbank_claim", 32'(hbank), 32'(h.bank));
            end
          end
          if (s.valid && s.ready) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("beat", 32'({s.last, s.data}), 32'(e));
            end
            beats++;
            last_byte = s.data;
          end
          if (rd_a[aw-1:0] == {aw{1'b1}}) top_cnt++;
          pv = s.valid;
          pr = s.ready;
          pe = {s.last, s.data};
          pstb = pkt_stb;
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hbank", 32'(hbank), 1);
    chk("rst_rd_a", 32'(rd_a), 0);
    chk("rst_valid", 32'(s.valid), 0);
    chk("rst_last", 32'(s.last), 0);
    chk("rst_data", 32'(s.data), 0);
    chk("rst_len", 32'(pkt_len), 0);
    chk("rst_status", 32'(pkt_status), 0);
    chk("rst_stb", 32'(pkt_stb), 0);
    chk("rst_err", 32'(len_err), 0);
    rst = 1'b0;
    rdy_mode = 0;
    b0 = beats;
    publish(11'd5, 8'h3C, 8'h10);
    wait_done(200);
    chk("t1_beats", 32'(beats - b0), 5);
    chk("t1_last_byte", 32'(last_byte), 32'h14);
    chk("t1_len", 32'(pkt_len), 5);
    chk("t1_status", 32'(pkt_status), 32'h3C);
    chk("t1_hbank", 32'(hbank), 0);
    rdy_mode = 1;
    b0 = beats;
    publish(11'd5, 8'h3C, 8'h10);
    wait_done(200);
    chk("t2_beats", 32'(beats - b0), 5);
    chk("t2_last_byte", 32'(last_byte), 32'h14);
    chk("t2_hbank", 32'(hbank), 1);
    rdy_mode = 2;
    publish(11'd12, 8'hA5, -1);
    publish(11'd7, 8'h5A, 8'h40);
    wait_done(400);
    chk("t3_last_byte", 32'(last_byte), 32'h46);
    rdy_mode = 0;
    b0 = beats;
    publish(11'd0, 8'h77, 0);
    wait_done(200);
    chk("t4_beats", 32'(beats - b0), 0);
    chk("t4_len", 32'(pkt_len), 0);
    chk("t4_status", 32'(pkt_status), 32'h77);
    b0 = beats;
    t = top_cnt;
    publish(11'd2047, 8'h99, -1);
    wait_done(5000);
    chk("t5_beats", 32'(beats - b0), 2044);
    chk("t5_len", 32'(pkt_len), 2044);
    chk("t5_err", 32'(len_err), 1);
    chk("t5_top_addr", 32'(top_cnt > t), 1);
    b0 = beats;
    publish(11'd10, 8'h11, 8'h20);
    n = 0;
    while (beats - b0 < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_beat3", 32'(beats - b0), 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_valid", 32'(s.valid), 0);
    chk("t6_hbank", 32'(hbank), 1);
    chk("t6_err", 32'(len_err), 0);
    exp_q.delete();
    hdr_q.delete();
    model_err = 1'b0;
    mac_bank = 1'b0;
    rst = 1'b0;
    b0 = beats;
    publish(11'd6, 8'h21, 8'h80);
    wait_done(300);
    chk("t6_after_beats", 32'(beats - b0), 6);
    chk("t6_after_last", 32'(last_byte), 32'h85);
    for (int k = 0; k < 14; k++) begin
      rdy_mode = $urandom_range(0, 2);
      publish(11'($urandom_range(0, 40)), 8'($urandom), -1);
      if ($urandom_range(0, 1) == 1) wait_done(600);
    end
    wait_done(2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
